// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: score word type and the sequencer state encoding.
package frame_seq_pkg;

    typedef logic signed [15:0] num;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_PROC  = 3'd1,
        S_NORM  = 3'd2,
        S_SEND  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/sram_client_mux.sv
// Routes one of the three phase clients onto the single SRAM port; drives zeros when no phase owns it.
module sram_client_mux
    import frame_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 16
) (
    input  state_t              sel,
    input  logic                proc_wr,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [DATA_W-1:0]   proc_wdata,
    input  logic                norm_rd,
    input  logic                norm_wr,
    input  logic [ADDR_W-1:0]   norm_addr,
    input  logic [DATA_W-1:0]   norm_wdata,
    input  logic                send_rd,
    input  logic                send_wr,
    input  logic [ADDR_W-1:0]   send_addr,
    input  logic [DATA_W-1:0]   send_wdata,
    output logic                rd_c,
    output logic                wr_c,
    output logic [ADDR_W-1:0]   addr_c,
    output logic [DATA_W-1:0]   wdata_c
);

    always_comb begin
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (sel)
            S_PROC: begin
                wr_c    = proc_wr;
                addr_c  = proc_addr;
                wdata_c = proc_wdata;
            end
            S_NORM: begin
                rd_c    = norm_rd;
                wr_c    = norm_wr;
                addr_c  = norm_addr;
                wdata_c = norm_wdata;
            end
            S_SEND: begin
                rd_c    = send_rd;
                wr_c    = send_wr;
                addr_c  = send_addr;
                wdata_c = send_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level controller: sequences each vector through PROC, NORM and SEND, queues one
// pending vector, guards every phase with a watchdog and owns the shared SRAM port.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned STRIDE_LOG2 = 1,
    parameter int unsigned WDOG_W      = 20,
    parameter int unsigned LED_W       = 26,
    parameter int unsigned OVR_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vec_valid,
    input  logic                last_senone,
    input  logic                norm_done,
    input  logic                send_done,
    input  logic                score_ready,
    input  logic [IDX_W-1:0]    senone_idx,
    input  logic [DATA_W-1:0]   senone_score,
    input  logic                norm_rd,
    input  logic                norm_wr,
    input  logic [ADDR_W-1:0]   norm_addr,
    input  logic [DATA_W-1:0]   norm_wdata,
    input  logic                send_rd,
    input  logic                send_wr,
    input  logic [ADDR_W-1:0]   send_addr,
    input  logic [DATA_W-1:0]   send_wdata,
    input  logic                sram_idle,
    input  logic                fault_clr,
    output logic                vec_accept,
    output logic                start_norm,
    output logic                start_send,
    output logic                sram_rd,
    output logic                sram_wr,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [STATE_W-1:0]  state_code,
    output logic                fault,
    output logic [OVR_W-1:0]    overruns,
    output logic [15:0]         frame_count,
    output logic                status_led
);

    localparam int unsigned FRAME_W = 16;

    state_t              state, state_d;
    logic                pending, pending_d;
    logic [OVR_W-1:0]    overruns_d;
    logic [FRAME_W-1:0]  frame_d;
    logic [WDOG_W-1:0]   wdog, wdog_d, wdog_inc;
    logic [LED_W-1:0]    presc, presc_d;
    logic                vec_accept_d, start_norm_d, start_send_d, fault_d, led_d;
    logic                active_c, expire_c, enter_proc_c;
    logic [ADDR_W-1:0]   proc_addr_c;

    assign state_code  = state;
    assign proc_addr_c = ADDR_W'(senone_idx) << STRIDE_LOG2;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            overruns    <= '0;
            frame_count <= '0;
            wdog        <= '0;
            presc       <= '0;
            vec_accept  <= 1'b0;
            start_norm  <= 1'b0;
            start_send  <= 1'b0;
            fault       <= 1'b0;
            status_led  <= 1'b1;
        end else begin
            state       <= state_d;
            pending     <= pending_d;
            overruns    <= overruns_d;
            frame_count <= frame_d;
            wdog        <= wdog_d;
            presc       <= presc_d;
            vec_accept  <= vec_accept_d;
            start_norm  <= start_norm_d;
            start_send  <= start_send_d;
            fault       <= fault_d;
            status_led  <= led_d;
        end
    end

    // Next-state, pending queue, counters and output next-values
    always_comb begin
        state_d    = state;
        pending_d  = pending;
        overruns_d = overruns;
        frame_d    = frame_count;
        presc_d    = presc + LED_W'(1);
        wdog_inc   = wdog + WDOG_W'(1);
        active_c   = (state == S_PROC) || (state == S_NORM) || (state == S_SEND);
        // The phase is abandoned on the edge where the counter would reach all-ones.
        expire_c   = active_c && (wdog_inc == '1);

        case (state)
            S_IDLE:  if (vec_valid || pending) state_d = S_PROC;
            S_PROC:  if (last_senone) state_d = S_NORM;
                     else if (expire_c) state_d = S_FAULT;
            S_NORM:  if (norm_done) state_d = S_SEND;
                     else if (expire_c) state_d = S_FAULT;
            S_SEND: begin
                if (send_done) begin
                    frame_d = frame_count + FRAME_W'(1);
                    state_d = (pending || vec_valid) ? S_PROC : S_IDLE;
                end else if (expire_c) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: if (fault_clr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        enter_proc_c = (state_d == S_PROC) && (state != S_PROC);

        // Entry takes the queued vector first; a simultaneous new one refills the slot.
        if (enter_proc_c) begin
            pending_d = pending & vec_valid;
        end else if (vec_valid) begin
            if (!pending) begin
                pending_d = 1'b1;
            end else if (overruns != '1) begin
                overruns_d = overruns + OVR_W'(1);
            end
        end

        wdog_d       = (state_d != state) ? '0 : (active_c ? wdog_inc : wdog);
        vec_accept_d = enter_proc_c;
        start_norm_d = (state == S_NORM) && (state_d == S_NORM) && (start_norm || sram_idle);
        start_send_d = (state == S_SEND) && (state_d == S_SEND) && (start_send || sram_idle);
        fault_d      = (state_d == S_FAULT);

        case (state_d)
            S_PROC:  led_d = presc_d[LED_W-1];
            S_NORM:  led_d = presc_d[LED_W-2];
            S_SEND:  led_d = presc_d[LED_W-3];
            S_FAULT: led_d = presc_d[LED_W-4];
            default: led_d = 1'b1;
        endcase
    end

    sram_client_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram_mux (
        .sel        (state),
        .proc_wr    (score_ready),
        .proc_addr  (proc_addr_c),
        .proc_wdata (senone_score),
        .norm_rd    (norm_rd),
        .norm_wr    (norm_wr),
        .norm_addr  (norm_addr),
        .norm_wdata (norm_wdata),
        .send_rd    (send_rd),
        .send_wr    (send_wr),
        .send_addr  (send_addr),
        .send_wdata (send_wdata),
        .rd_c       (sram_rd),
        .wr_c       (sram_wr),
        .addr_c     (sram_addr),
        .wdata_c    (sram_wdata)
    );

endmodule
